friscv_icache_blkfill: RTL and testbench

Instruction-cache line-fill controller between the fetch stage's AXI4-lite read requests and the AXI4 central-memory read channels. It generalises single-beat filling to multi-beat INCR bursts, so the cache line can be wider than the AXI data bus. It tracks up to MAX_OSTD in-order outstanding fills, assembles each burst into a full line, and writes it to the cache RAM. It also drains in-flight traffic and erases the whole cache on a FENCE.i flush.

---
 rtl/friscv_icache_blkfill.sv | 209 ++++++++++++++++++++
 tb/tb_friscv_icache_blkfill.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/friscv_icache_blkfill.sv
// Icache line filler: fetch AR -> INCR burst, beats assembled into a line, written 1 cycle after RLAST; AR is pass-through, stalls when MAX_OSTD fills pend.
// FENCE.i drains then erases every line. Define ICACHE_FILL_CHECK_EN to drop lines with bad RRESP/RLAST placement and pulse fill_err.
module friscv_icache_blkfill #(
  parameter int AXI_ADDR_W    = 32,
  parameter int AXI_ID_W      = 8,
  parameter int AXI_DATA_W    = 32,
  parameter int AXI_ID_MASK   = 'h10,
  parameter int CACHE_BLOCK_W = 128,
  parameter int CACHE_DEPTH   = 512,
  parameter int MAX_OSTD      = 4
)(
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     srst,
  input  logic                     flush_req,
  output logic                     flush_ack,
  output logic                     flush,
  input  logic                     ctrl_arvalid,
  output logic                     ctrl_arready,
  input  logic [AXI_ADDR_W-1:0]    ctrl_araddr,
  input  logic [2:0]               ctrl_arprot,
  input  logic [AXI_ID_W-1:0]      ctrl_arid,
  output logic                     mem_arvalid,
  input  logic                     mem_arready,
  output logic [AXI_ADDR_W-1:0]    mem_araddr,
  output logic [7:0]               mem_arlen,
  output logic [2:0]               mem_arsize,
  output logic [1:0]               mem_arburst,
  output logic [1:0]               mem_arlock,
  output logic [3:0]               mem_arcache,
  output logic [2:0]               mem_arprot,
  output logic [3:0]               mem_arqos,
  output logic [3:0]               mem_arregion,
  output logic [AXI_ID_W-1:0]      mem_arid,
  input  logic                     mem_rvalid,
  output logic                     mem_rready,
  input  logic [AXI_ID_W-1:0]      mem_rid,
  input  logic [1:0]               mem_rresp,
  input  logic [AXI_DATA_W-1:0]    mem_rdata,
  input  logic                     mem_rlast,
  output logic                     cache_wen,
  output logic [AXI_ADDR_W-1:0]    cache_waddr,
  output logic [CACHE_BLOCK_W-1:0] cache_wdata,
  output logic                     fill_err
);

  localparam int BEATS = CACHE_BLOCK_W / AXI_DATA_W;
  localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W = $clog2(MAX_OSTD);
  localparam int CNT_W = PTR_W + 1;
  localparam int OFF_W = $clog2(CACHE_BLOCK_W / 8);
  localparam int ER_W  = (CACHE_DEPTH > 1) ? $clog2(CACHE_DEPTH) : 1;
  localparam logic [AXI_ADDR_W-1:0] ALIGN_MASK = {AXI_ADDR_W{1'b1}} << OFF_W;

  typedef enum logic [1:0] {IDLE, DRAIN, ERASE, ACK} state_t;

  state_t                   state_q, state_d;
  logic [PTR_W-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [BC_W-1:0]          beat_cnt_q, beat_cnt_d;
  logic [ER_W-1:0]          erase_cnt_q, erase_cnt_d;
  logic [CACHE_BLOCK_W-1:0] line_q, line_d, wdata_q, wdata_d;
  logic [AXI_ADDR_W-1:0]    waddr_q, waddr_d;
  logic                     wen_q, wen_d, err_q, err_d, fill_err_q, fill_err_d;
  logic [AXI_ADDR_W-1:0]    addr_fifo_q [MAX_OSTD];

  logic full, empty, idle, erasing, push, beat, pop, last_beat, beat_err;

  assign mem_arlen    = 8'(BEATS - 1);
  assign mem_arsize   = 3'($clog2(AXI_DATA_W / 8));
  assign mem_arburst  = 2'b01;
  assign mem_arlock   = '0;
  assign mem_arcache  = '0;
  assign mem_arqos    = '0;
  assign mem_arregion = '0;
  assign mem_arprot   = ctrl_arprot;
  assign mem_arid     = ctrl_arid | AXI_ID_W'(AXI_ID_MASK);
  assign mem_araddr   = ctrl_araddr & ALIGN_MASK;

  assign full      = (cnt_q == CNT_W'(MAX_OSTD));
  assign empty     = (cnt_q == '0);
  assign idle      = (state_q == IDLE);
  assign erasing   = (state_q == ERASE);
  assign last_beat = (beat_cnt_q == BC_W'(BEATS - 1));

  assign mem_arvalid  = ctrl_arvalid & !full & idle;
  assign ctrl_arready = mem_arready & !full & idle;
  assign mem_rready   = !empty;
  assign push = mem_arvalid & mem_arready;
  assign beat = mem_rvalid & mem_rready;
  assign pop  = beat & mem_rlast;

  assign flush       = erasing;
  assign flush_ack   = (state_q == ACK) & flush_req;
  assign cache_wen   = erasing | wen_q;
  assign cache_waddr = erasing ? (AXI_ADDR_W'(erase_cnt_q) << OFF_W) : waddr_q;
  assign cache_wdata = erasing ? '0 : wdata_q;

`ifdef ICACHE_FILL_CHECK_EN
  // RLAST must coincide exactly with the final beat slot
  assign beat_err = (mem_rresp != 2'b00) | (mem_rlast ^ last_beat);
  assign fill_err = fill_err_q;
  logic unused_sig;
  assign unused_sig = ^mem_rid;
`else
  assign beat_err = 1'b0;
  assign fill_err = 1'b0;
  logic unused_sig;
  assign unused_sig = ^{mem_rid, mem_rresp, fill_err_q};
`endif

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    cnt_d       = cnt_q + CNT_W'(push) - CNT_W'(pop);
    beat_cnt_d  = beat_cnt_q;
    erase_cnt_d = erase_cnt_q;
    line_d      = line_q;
    wdata_d     = wdata_q;
    waddr_d     = waddr_q;
    wen_d       = 1'b0;
    err_d       = err_q;
    fill_err_d  = 1'b0;

    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;

    if (beat) begin
      line_d[beat_cnt_q*AXI_DATA_W +: AXI_DATA_W] = mem_rdata;
      if (mem_rlast) begin
        beat_cnt_d = '0;
        err_d      = 1'b0;
        wen_d      = !(err_q | beat_err);
        fill_err_d = err_q | beat_err;
        wdata_d    = line_d;
        waddr_d    = addr_fifo_q[rptr_q];
      end else begin
        err_d = err_q | beat_err;
        // overlong bursts keep landing in the last slot until RLAST
        if (!last_beat) beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end

    case (state_q)
      IDLE:  if (flush_req) state_d = DRAIN;
      DRAIN: if (empty && beat_cnt_q == '0) state_d = ERASE;
      ERASE: begin
        erase_cnt_d = erase_cnt_q + 1'b1;
        if (erase_cnt_q == ER_W'(CACHE_DEPTH - 1)) begin
          erase_cnt_d = '0;
          state_d     = ACK;
        end
      end
      ACK:     if (!flush_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (srst) begin
      state_d     = IDLE;
      wptr_d      = '0;
      rptr_d      = '0;
      cnt_d       = '0;
      beat_cnt_d  = '0;
      erase_cnt_d = '0;
      line_d      = '0;
      wdata_d     = '0;
      waddr_d     = '0;
      wen_d       = 1'b0;
      err_d       = 1'b0;
      fill_err_d  = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      beat_cnt_q  <= '0;
      erase_cnt_q <= '0;
      line_q      <= '0;
      wdata_q     <= '0;
      waddr_q     <= '0;
      wen_q       <= 1'b0;
      err_q       <= 1'b0;
      fill_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      erase_cnt_q <= erase_cnt_d;
      line_q      <= line_d;
      wdata_q     <= wdata_d;
      waddr_q     <= waddr_d;
      wen_q       <= wen_d;
      err_q       <= err_d;
      fill_err_q  <= fill_err_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) addr_fifo_q[wptr_q] <= mem_araddr;
  end

endmodule

// File: tb/tb_friscv_icache_blkfill.sv
// Directed bench for friscv_icache_blkfill: 32-bit beats, 128-bit lines, 8-line cache, 4 outstanding fills.
module tb_friscv_icache_blkfill;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b1;
  logic         srst = 1'b0;
  logic         flush_req = 1'b0;
  logic         flush_ack, flush;
  logic         ctrl_arvalid = 1'b0;
  logic         ctrl_arready;
  logic [31:0]  ctrl_araddr = '0;
  logic [2:0]   ctrl_arprot = '0;
  logic [7:0]   ctrl_arid = '0;
  logic         mem_arvalid;
  logic         mem_arready = 1'b0;
  logic [31:0]  mem_araddr;
  logic [7:0]   mem_arlen;
  logic [2:0]   mem_arsize;
  logic [1:0]   mem_arburst, mem_arlock;
  logic [3:0]   mem_arcache, mem_arqos, mem_arregion;
  logic [2:0]   mem_arprot;
  logic [7:0]   mem_arid;
  logic         mem_rvalid = 1'b0;
  logic         mem_rready;
  logic [7:0]   mem_rid = '0;
  logic [1:0]   mem_rresp = '0;
  logic [31:0]  mem_rdata = '0;
  logic         mem_rlast = 1'b0;
  logic         cache_wen;
  logic [31:0]  cache_waddr;
  logic [127:0] cache_wdata;
  logic         fill_err;

  friscv_icache_blkfill #(
    .AXI_ADDR_W(32), .AXI_ID_W(8), .AXI_DATA_W(32), .AXI_ID_MASK('h10),
    .CACHE_BLOCK_W(128), .CACHE_DEPTH(8), .MAX_OSTD(4)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .flush_req(flush_req), .flush_ack(flush_ack), .flush(flush),
    .ctrl_arvalid(ctrl_arvalid), .ctrl_arready(ctrl_arready), .ctrl_araddr(ctrl_araddr),
    .ctrl_arprot(ctrl_arprot), .ctrl_arid(ctrl_arid),
    .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
    .mem_arlen(mem_arlen), .mem_arsize(mem_arsize), .mem_arburst(mem_arburst),
    .mem_arlock(mem_arlock), .mem_arcache(mem_arcache), .mem_arprot(mem_arprot),
    .mem_arqos(mem_arqos), .mem_arregion(mem_arregion), .mem_arid(mem_arid),
    .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rid(mem_rid),
    .mem_rresp(mem_rresp), .mem_rdata(mem_rdata), .mem_rlast(mem_rlast),
    .cache_wen(cache_wen), .cache_waddr(cache_waddr), .cache_wdata(cache_wdata),
    .fill_err(fill_err)
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int err_pulses = 0;
  int ack_cyc = 0;
  logic [31:0]  wq_addr[$];
  logic [127:0] wq_data[$];
  int           wq_cyc[$];
  logic         wq_flush[$];

  always @(negedge aclk) begin
    cyc++;
    if (cache_wen === 1'b1) begin
      wq_addr.push_back(cache_waddr);
      wq_data.push_back(cache_wdata);
      wq_cyc.push_back(cyc);
      wq_flush.push_back(flush);
    end
    if (fill_err === 1'b1) err_pulses++;
    if (flush_ack === 1'b1 && ack_cyc == 0) ack_cyc = cyc;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_mon;
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete(); wq_flush.delete();
    err_pulses = 0;
    ack_cyc = 0;
  endtask

  function automatic logic [127:0] line_of(input logic [31:0] b);
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  task automatic ar_req(input logic [31:0] addr, input logic [7:0] id, input logic [31:0] exp_addr);
    ctrl_arvalid = 1'b1; ctrl_araddr = addr; ctrl_arid = id; mem_arready = 1'b1;
    #1;
    n_cmp++;
    if (mem_arvalid !== 1'b1 || ctrl_arready !== 1'b1) begin
      n_err++; $display("FAIL ar_handshake: arvalid=%b arready=%b want 1/1", mem_arvalid, ctrl_arready);
    end
    n_cmp++;
    if (mem_araddr !== exp_addr) begin
      n_err++; $display("FAIL ar_addr: got %h want %h", mem_araddr, exp_addr);
    end
    n_cmp++;
    if (mem_arid !== (id | 8'h10)) begin
      n_err++; $display("FAIL ar_id: got %h want %h", mem_arid, id | 8'h10);
    end
    tick;
    ctrl_arvalid = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last, input logic [1:0] resp);
    mem_rvalid = 1'b1; mem_rdata = d; mem_rlast = last; mem_rresp = resp;
    tick;
    mem_rvalid = 1'b0; mem_rlast = 1'b0; mem_rresp = 2'b00;
  endtask

  task automatic send_burst(input logic [31:0] b);
    for (int j = 0; j < 4; j++) send_beat(b + 32'(j), j == 3, 2'b00);
  endtask

  task automatic wait_wq(input int n, input int budget, input string tag);
    int k = 0;
    while (wq_addr.size() < n && k < budget) begin tick; k++; end
    n_cmp++;
    if (wq_addr.size() < n) begin
      n_err++; $display("FAIL %s: got %0d cache writes, want %0d", tag, wq_addr.size(), n);
    end
  endtask

  task automatic test_reset;
    aresetn = 1'b1; #1; aresetn = 1'b0;
    tick; tick;
    n_cmp++;
    if ({mem_arvalid, ctrl_arready, mem_rready, cache_wen, flush, flush_ack, fill_err} !== 7'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 0000000",
        {mem_arvalid, ctrl_arready, mem_rready, cache_wen, flush, flush_ack, fill_err});
    end
    n_cmp++;
    if (cache_waddr !== 32'h0 || cache_wdata !== 128'h0) begin
      n_err++; $display("FAIL reset_wport: addr=%h data=%h want 0", cache_waddr, cache_wdata);
    end
    n_cmp++;
    if ({mem_arlen, mem_arsize, mem_arburst} !== {8'd3, 3'd2, 2'b01}) begin
      n_err++; $display("FAIL ar_const: len=%0d size=%0d burst=%0d want 3/2/1", mem_arlen, mem_arsize, mem_arburst);
    end
    n_cmp++;
    if ({mem_arlock, mem_arcache, mem_arqos, mem_arregion} !== 14'b0) begin
      n_err++; $display("FAIL ar_zero: lock=%h cache=%h qos=%h region=%h want 0", mem_arlock, mem_arcache, mem_arqos, mem_arregion);
    end
    aresetn = 1'b1;
    mem_arready = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    clear_mon;
    ar_req(32'h1004, 8'h05, 32'h1000);
    send_beat(32'hAAAA0001, 1'b0, 2'b00);
    send_beat(32'hBBBB0002, 1'b0, 2'b00);
    send_beat(32'hCCCC0003, 1'b0, 2'b00);
    n_cmp++;
    if (cache_wen !== 1'b0) begin
      n_err++; $display("FAIL basic_early_wen: got %b want 0", cache_wen);
    end
    send_beat(32'hDDDD0004, 1'b1, 2'b00);
    n_cmp++;
    if (cache_wen !== 1'b1 || cache_waddr !== 32'h1000) begin
      n_err++; $display("FAIL basic_write: wen=%b addr=%h want 1/00001000", cache_wen, cache_waddr);
    end
    n_cmp++;
    if (cache_wdata !== 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001) begin
      n_err++; $display("FAIL basic_data: got %h want DDDD0004CCCC0003BBBB0002AAAA0001", cache_wdata);
    end
    tick;
    n_cmp++;
    if (cache_wen !== 1'b0 || mem_rready !== 1'b0) begin
      n_err++; $display("FAIL basic_after: wen=%b rready=%b want 0/0", cache_wen, mem_rready);
    end
  endtask

  task automatic test_full;
    clear_mon;
    for (int i = 0; i < 4; i++) begin
      ctrl_arvalid = 1'b1; ctrl_araddr = 32'h2000 + 32'(16 * i); mem_arready = 1'b1;
      #1;
      n_cmp++;
      if (ctrl_arready !== 1'b1) begin
        n_err++; $display("FAIL full_accept%0d: arready=%b want 1", i, ctrl_arready);
      end
      tick;
    end
    ctrl_araddr = 32'h2040;
    #1;
    n_cmp++;
    if (ctrl_arready !== 1'b0 || mem_arvalid !== 1'b0) begin
      n_err++; $display("FAIL full_block: arready=%b arvalid=%b want 0/0", ctrl_arready, mem_arvalid);
    end
    tick;
    send_burst(32'h2000_0000);
    n_cmp++;
    if (ctrl_arready !== 1'b1) begin
      n_err++; $display("FAIL full_release: arready=%b want 1", ctrl_arready);
    end
    tick;
    ctrl_arvalid = 1'b0;
    for (int i = 1; i < 5; i++) send_burst(32'h2000_0000 + 32'(16 * i));
    wait_wq(5, 10, "full_writes");
    tick;
    n_cmp++;
    if (wq_addr.size() != 5) begin
      n_err++; $display("FAIL full_count: got %0d writes want 5", wq_addr.size());
    end
    for (int i = 0; i < 5 && i < wq_addr.size(); i++) begin
      n_cmp++;
      if (wq_addr[i] !== 32'h2000 + 32'(16 * i)) begin
        n_err++; $display("FAIL full_addr%0d: got %h want %h", i, wq_addr[i], 32'h2000 + 32'(16 * i));
      end
    end
  endtask

  task automatic test_back_to_back;
    clear_mon;
    ar_req(32'h0, 8'h01, 32'h0);
    ar_req(32'h10, 8'h02, 32'h10);
    ar_req(32'h20, 8'h03, 32'h20);
    for (int k = 0; k < 3; k++) send_burst(32'hC000_0000 + 32'(16 * k));
    wait_wq(3, 6, "b2b_writes");
    for (int k = 0; k < 3 && k < wq_addr.size(); k++) begin
      n_cmp++;
      if (wq_addr[k] !== 32'(16 * k) || wq_data[k] !== line_of(32'hC000_0000 + 32'(16 * k))) begin
        n_err++; $display("FAIL b2b_line%0d: addr=%h data=%h want %h/%h", k, wq_addr[k], wq_data[k],
          32'(16 * k), line_of(32'hC000_0000 + 32'(16 * k)));
      end
      if (k > 0) begin
        n_cmp++;
        if (wq_cyc[k] - wq_cyc[k-1] != 4) begin
          n_err++; $display("FAIL b2b_spacing%0d: got %0d cycles want 4", k, wq_cyc[k] - wq_cyc[k-1]);
        end
      end
    end
  endtask

  task automatic test_flush;
    int k = 0;
    clear_mon;
    ar_req(32'h3000, 8'h07, 32'h3000);
    ar_req(32'h3010, 8'h08, 32'h3010);
    flush_req = 1'b1;
    tick;
    ctrl_arvalid = 1'b1; ctrl_araddr = 32'h3020;
    #1;
    n_cmp++;
    if (ctrl_arready !== 1'b0 || mem_arvalid !== 1'b0) begin
      n_err++; $display("FAIL drain_block: arready=%b arvalid=%b want 0/0", ctrl_arready, mem_arvalid);
    end
    ctrl_arvalid = 1'b0;
    send_burst(32'hF000_0000);
    send_burst(32'hF000_0010);
    while (flush_ack !== 1'b1 && k < 40) begin tick; k++; end
    n_cmp++;
    if (flush_ack !== 1'b1) begin
      n_err++; $display("FAIL flush_ack_wait: ack=%b want 1 within 40 cycles", flush_ack);
    end
    tick;
    n_cmp++;
    if (flush_ack !== 1'b1 || flush !== 1'b0) begin
      n_err++; $display("FAIL flush_ack_hold: ack=%b flush=%b want 1/0", flush_ack, flush);
    end
    n_cmp++;
    if (wq_addr.size() != 10) begin
      n_err++; $display("FAIL flush_count: got %0d writes want 10", wq_addr.size());
    end else begin
      n_cmp++;
      if (wq_addr[0] !== 32'h3000 || wq_addr[1] !== 32'h3010 || wq_data[1] !== line_of(32'hF000_0010)
          || wq_flush[1] !== 1'b0) begin
        n_err++; $display("FAIL flush_fills: a0=%h a1=%h d1=%h want 3000/3010/%h", wq_addr[0], wq_addr[1],
          wq_data[1], line_of(32'hF000_0010));
      end
      for (int n = 0; n < 8; n++) begin
        n_cmp++;
        if (wq_addr[2+n] !== 32'(16 * n) || wq_data[2+n] !== 128'h0 || wq_flush[2+n] !== 1'b1
            || wq_cyc[2+n] != wq_cyc[1] + 1 + n) begin
          n_err++; $display("FAIL erase%0d: addr=%h data=%h flush=%b cyc=%0d want %h/0/1/%0d", n, wq_addr[2+n],
            wq_data[2+n], wq_flush[2+n], wq_cyc[2+n], 32'(16 * n), wq_cyc[1] + 1 + n);
        end
      end
      n_cmp++;
      if (ack_cyc != wq_cyc[9] + 1) begin
        n_err++; $display("FAIL flush_ack_latency: ack at %0d want %0d", ack_cyc, wq_cyc[9] + 1);
      end
    end
    flush_req = 1'b0;
    #1;
    n_cmp++;
    if (flush_ack !== 1'b0) begin
      n_err++; $display("FAIL flush_ack_drop: ack=%b want 0", flush_ack);
    end
    tick;
    n_cmp++;
    if (ctrl_arready !== 1'b1) begin
      n_err++; $display("FAIL flush_return_idle: arready=%b want 1", ctrl_arready);
    end
  endtask

  task automatic test_fill_err;
    clear_mon;
    ar_req(32'h4000, 8'h09, 32'h4000);
    send_beat(32'h4400_0000, 1'b0, 2'b00);
    send_beat(32'h4400_0001, 1'b0, 2'b00);
    send_beat(32'h4400_0002, 1'b0, 2'b10);
    send_beat(32'h4400_0003, 1'b1, 2'b00);
    tick;
    ar_req(32'h4010, 8'h0A, 32'h4010);
    send_burst(32'h4500_0000);
    tick; tick;
`ifdef ICACHE_FILL_CHECK_EN
    n_cmp++;
    if (wq_addr.size() != 1 || err_pulses != 1) begin
      n_err++; $display("FAIL err_drop: writes=%0d fill_err cycles=%0d want 1/1", wq_addr.size(), err_pulses);
    end
`else
    n_cmp++;
    if (wq_addr.size() != 2 || err_pulses != 0) begin
      n_err++; $display("FAIL err_ignored: writes=%0d fill_err cycles=%0d want 2/0", wq_addr.size(), err_pulses);
    end
`endif
    n_cmp++;
    if (wq_addr.size() == 0) begin
      n_err++; $display("FAIL err_next_fill: no cache write seen, want write at 00004010");
    end else if (wq_addr[wq_addr.size()-1] !== 32'h4010 || wq_data[wq_data.size()-1] !== line_of(32'h4500_0000)) begin
      n_err++; $display("FAIL err_next_fill: addr=%h data=%h want 00004010/%h", wq_addr[wq_addr.size()-1],
        wq_data[wq_data.size()-1], line_of(32'h4500_0000));
    end
  endtask

  task automatic test_reset_mid;
    clear_mon;
    ar_req(32'h5000, 8'h0B, 32'h5000);
    send_beat(32'h5500_0000, 1'b0, 2'b00);
    mem_rvalid = 1'b1; mem_rdata = 32'h5500_0001;
    #2;
    aresetn = 1'b0;
    #1;
    n_cmp++;
    if ({mem_rready, cache_wen, flush, flush_ack, fill_err, mem_arvalid} !== 6'b0) begin
      n_err++; $display("FAIL midreset_outputs: got %b want 000000",
        {mem_rready, cache_wen, flush, flush_ack, fill_err, mem_arvalid});
    end
    tick;
    mem_rvalid = 1'b0;
    aresetn = 1'b1;
    tick; tick; tick;
    n_cmp++;
    if (wq_addr.size() != 0 || mem_rready !== 1'b0) begin
      n_err++; $display("FAIL midreset_discard: writes=%0d rready=%b want 0/0", wq_addr.size(), mem_rready);
    end
    ar_req(32'h6008, 8'h0C, 32'h6000);
    send_burst(32'h6600_0000);
    tick;
    n_cmp++;
    if (wq_addr.size() != 1) begin
      n_err++; $display("FAIL midreset_refill: writes=%0d want 1", wq_addr.size());
    end else if (wq_addr[0] !== 32'h6000 || wq_data[0] !== line_of(32'h6600_0000)) begin
      n_err++; $display("FAIL midreset_refill: addr=%h data=%h want 00006000/%h", wq_addr[0], wq_data[0],
        line_of(32'h6600_0000));
    end
  endtask

  task automatic test_srst;
    clear_mon;
    ar_req(32'h7000, 8'h0D, 32'h7000);
    n_cmp++;
    if (mem_rready !== 1'b1) begin
      n_err++; $display("FAIL srst_pending: rready=%b want 1", mem_rready);
    end
    srst = 1'b1;
    tick;
    srst = 1'b0;
    n_cmp++;
    if (mem_rready !== 1'b0 || cache_wen !== 1'b0) begin
      n_err++; $display("FAIL srst_clear: rready=%b wen=%b want 0/0", mem_rready, cache_wen);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_full;
    test_back_to_back;
    test_flush;
    test_fill_err;
    test_reset_mid;
    test_srst;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
